// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the UART receive path.
//   - 3-bit receive FSM state encoding
//   - frame geometry constants (data bits, index of the last data bit)
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int         DATA_BITS = 8;
  localparam logic [2:0] LAST_BIT  = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: receive-side controller for the UART RX path.
// Sequences the edge/bit counter, data sampler, deserializer and parity
// checker through start, data, optional parity and stop phases. Rejects
// start glitches, checks the stop bit and reports each completed byte.
//
// Ports
//   CLK, RST         oversampling clock, async active-low reset
//   RX_IN            synchronized serial line (idle high)
//   PAR_EN           parity bit present in the frame
//   prescaler        oversampling ratio (8/16/32), static while busy
//   Edge_Counter     edge index within the current bit
//   Bit_Counter      data bit index
//   Done             last edge of the current bit
//   sampled_bit      majority-voted line value
//   par_err_in       parity checker result
//   Edge_EN_CNT      edge counter enable
//   Bit_EN_CNT       bit counter enable (0 clears the bit counter)
//   dat_samp_en      data sampler enable
//   deser_en         one-cycle deserializer shift strobe
//   par_chk_en       one-cycle parity checker strobe
//   data_valid       one-cycle pulse, byte accepted without error
//   par_err/stp_err  error flags of the last completed frame
//   busy             FSM not idle
module uart_rx_fsm
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] prescaler,
  input  logic [4:0] Edge_Counter,
  input  logic [2:0] Bit_Counter,
  input  logic       Done,
  input  logic       sampled_bit,
  input  logic       par_err_in,
  output logic       Edge_EN_CNT,
  output logic       Bit_EN_CNT,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       par_chk_en,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
);

  rx_state_t  state;
  logic       glitch;
  logic       pe;
  logic       se;

  // Check edge sits just past mid-bit: 5, 9 or 17 for prescaler 8, 16, 32.
  logic [5:0] chk;
  logic [5:0] edge_z;
  logic       at_chk;
  logic       at_chk1;
  logic       pe_eff;

  assign chk     = {1'b0, prescaler[5:1]} + 6'd1;
  assign edge_z  = {1'b0, Edge_Counter};
  assign at_chk  = (edge_z == chk);
  // Parity checker result is ready one edge after its strobe.
  assign at_chk1 = (edge_z == (chk + 6'd1));
  assign pe_eff  = PAR_EN & pe;

  assign busy = (state != IDLE);

  // Enables are decoded combinationally so the counters react in the same
  // cycle the state changes.
  always_comb begin
    Edge_EN_CNT = 1'b0;
    Bit_EN_CNT  = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    case (state)
      START: begin
        Edge_EN_CNT = 1'b1;
        dat_samp_en = 1'b1;
      end
      DATA: begin
        Edge_EN_CNT = 1'b1;
        Bit_EN_CNT  = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = at_chk;
      end
      PARITY: begin
        Edge_EN_CNT = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = at_chk;
      end
      STOP: begin
        Edge_EN_CNT = 1'b1;
        dat_samp_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      glitch     <= 1'b0;
      pe         <= 1'b0;
      se         <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state <= START;
            pe    <= 1'b0;
            se    <= 1'b0;
          end
        end
        START: begin
          if (at_chk) glitch <= sampled_bit;
          // A false start is only dropped at the end of the bit so the
          // counter wraps back to 0 before IDLE.
          if (Done) state <= glitch ? IDLE : DATA;
        end
        DATA: begin
          if (Done && (Bit_Counter == LAST_BIT))
            state <= PAR_EN ? PARITY : STOP;
        end
        PARITY: begin
          if (at_chk1) pe <= par_err_in;
          if (Done) state <= STOP;
        end
        STOP: begin
          if (at_chk) se <= ~sampled_bit;
          if (Done) begin
            state      <= IDLE;
            par_err    <= pe_eff;
            stp_err    <= se;
            data_valid <= ~(pe_eff | se);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed bench for uart_rx_fsm. Models the edge/bit
// counter and the data sampler around the DUT and checks frame timing,
// strobes and error reporting against hand-computed values.
module tb_uart_rx_fsm;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] psc;
  logic [4:0] ec;
  logic [2:0] bc;
  logic       done;
  logic       sampled_bit;
  logic       pei;
  logic       Edge_EN_CNT, Bit_EN_CNT, dat_samp_en, deser_en, par_chk_en;
  logic       data_valid, par_err, stp_err, busy;

  logic [15:0] fbits;
  logic [3:0]  bpos;

  int total = 0;
  int bad   = 0;

  // per-frame observations
  int   nd, npc, ndv, lat;
  logic [4:0] de, pce;
  logic first_busy, first_een, tmo, pf, sf, dv2;

  uart_rx_fsm dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescaler(psc),
    .Edge_Counter(ec), .Bit_Counter(bc), .Done(done), .sampled_bit(sampled_bit),
    .par_err_in(pei), .Edge_EN_CNT(Edge_EN_CNT), .Bit_EN_CNT(Bit_EN_CNT),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // edge/bit counter and bit-position environment model
  assign done        = ({1'b0, ec} == (psc - 6'd1));
  assign sampled_bit = fbits[bpos];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ec   <= '0;
      bc   <= '0;
      bpos <= '0;
    end else begin
      if (Edge_EN_CNT) ec <= done ? 5'd0 : ec + 5'd1;
      else             ec <= 5'd0;
      if (!Bit_EN_CNT) bc <= 3'd0;
      else if (done)   bc <= bc + 3'd1;
      if (!Edge_EN_CNT) bpos <= 4'd0;
      else if (done)    bpos <= bpos + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Drive one frame; called at a negedge. keep_low leaves RX_IN low so the
  // next frame starts right after this one ends.
  task automatic run_frame(input logic [5:0] p, input logic pen, input logic [7:0] d,
                           input logic pe_in, input logic sbit, input logic gl,
                           input int low_n, input logic keep_low);
    logic seen;
    psc    = p;
    PAR_EN = pen;
    pei    = pe_in;
    fbits  = '1;
    fbits[0] = gl;
    for (int i = 0; i < 8; i++) fbits[i+1] = d[i];
    if (pen) begin
      fbits[9]  = ^d;
      fbits[10] = sbit;
    end else begin
      fbits[9] = sbit;
    end
    nd = 0; npc = 0; ndv = 0; lat = 0; de = '0; pce = '0;
    seen = 1'b0; tmo = 1'b1; dv2 = 1'b0;
    first_busy = 1'b0; first_een = 1'b0;
    RX_IN = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge CLK);
      if (n == 0) begin
        first_busy = busy;
        first_een  = Edge_EN_CNT;
      end
      if (deser_en)   begin nd++;  de  = ec; end
      if (par_chk_en) begin npc++; pce = ec; end
      if (data_valid) ndv++;
      if (busy) begin seen = 1'b1; lat++; end
      if (!keep_low && (n + 1 >= low_n)) RX_IN = 1'b1;
      if (seen && !busy) begin tmo = 1'b0; break; end
    end
    pf = par_err;
    sf = stp_err;
    if (!keep_low) begin
      @(negedge CLK);
      dv2 = data_valid;
    end
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; psc = 6'd8; pei = 1'b0; fbits = '1;
    repeat (3) @(negedge CLK);
    chk("rst_outs", {Edge_EN_CNT, Bit_EN_CNT, dat_samp_en, deser_en, par_chk_en,
                     data_valid, par_err, stp_err, busy}, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_busy", busy, 0);

    // 1: prescaler 8, no parity, 0xA5
    run_frame(6'd8, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    chk("f1_tmo", tmo, 0);
    chk("f1_start_busy", first_busy, 1);
    chk("f1_start_een", first_een, 1);
    chk("f1_ndeser", nd, 8);
    chk("f1_deser_edge", de, 5);
    chk("f1_lat", lat, 80);
    chk("f1_ndv", ndv, 1);
    chk("f1_dv_pulse", dv2, 0);
    chk("f1_pe", pf, 0);
    chk("f1_se", sf, 0);

    // 2: prescaler 16, parity, 0x3C, good parity
    run_frame(6'd16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    chk("f2_tmo", tmo, 0);
    chk("f2_lat", lat, 176);
    chk("f2_npc", npc, 1);
    chk("f2_pc_edge", pce, 9);
    chk("f2_ndeser", nd, 8);
    chk("f2_ndv", ndv, 1);
    chk("f2_pe", pf, 0);

    // 3: prescaler 32, stop bit 0
    run_frame(6'd32, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    chk("f3_tmo", tmo, 0);
    chk("f3_lat", lat, 320);
    chk("f3_deser_edge", de, 17);
    chk("f3_ndv", ndv, 0);
    chk("f3_se", sf, 1);
    chk("f3_pe", pf, 0);

    // 4: start glitch at prescaler 16, RX_IN low 3 cycles
    run_frame(6'd16, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    chk("gl_tmo", tmo, 0);
    chk("gl_lat", lat, 16);
    chk("gl_ndeser", nd, 0);
    chk("gl_ndv", ndv, 0);
    chk("gl_se_hold", sf, 1);
    chk("gl_pe_hold", pf, 0);

    // 5: good frame at prescaler 32 clears stp_err
    run_frame(6'd32, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    chk("f5_ndv", ndv, 1);
    chk("f5_se", sf, 0);
    chk("f5_lat", lat, 320);

    // 6: parity error, then back-to-back good frame
    run_frame(6'd16, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1, 1'b1);
    chk("f6_tmo", tmo, 0);
    chk("f6_ndv", ndv, 0);
    chk("f6_pe", pf, 1);
    chk("f6_se", sf, 0);
    run_frame(6'd16, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    chk("f7_b2b_busy", first_busy, 1);
    chk("f7_lat", lat, 176);
    chk("f7_ndv", ndv, 1);
    chk("f7_pe", pf, 0);

    // 7: parity error frame to set par_err, then reset during DATA
    run_frame(6'd8, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    chk("f8_pe", pf, 1);
    psc = 6'd8; PAR_EN = 1'b0; pei = 1'b0; fbits = '1; fbits[0] = 1'b0;
    RX_IN = 1'b0;
    tmo = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
      if (Bit_EN_CNT && (bc == 3'd4)) begin tmo = 1'b0; break; end
    end
    chk("rst_reach_bit4", tmo, 0);
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_outs", {Edge_EN_CNT, Bit_EN_CNT, dat_samp_en, deser_en, par_chk_en,
                         data_valid, par_err, stp_err, busy}, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_frame(6'd8, 1'b0, 8'hE7, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    chk("f9_tmo", tmo, 0);
    chk("f9_ndeser", nd, 8);
    chk("f9_lat", lat, 80);
    chk("f9_ndv", ndv, 1);
    chk("f9_flags", {pf, sf}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side controller for the UART RX path. It sequences the edge/bit counter, the oversampling data sampler, the deserializer and the parity checker through start, data, optional parity and stop phases. It runs start-glitch and stop-bit checks itself and reports a validated byte with error flags. It sits between the RX_IN pin synchronizer and the register-file/FIFO write side.

## Interface
- No parameters; frame format is 1 start, 8 data, optional even/odd parity, 1 stop.
- CLK  in  1  RX oversampling clock.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  synchronized serial line, idle high.
- PAR_EN  in  1  parity bit present in frame.
- prescaler  in  6  oversampling ratio; legal values 8, 16, 32; static while busy=1.
- Edge_Counter  in  5  edge count within current bit, from edge/bit counter.
- Bit_Counter  in  3  data-bit index, from edge/bit counter.
- Done  in  1  Edge_Counter == prescaler-1 (last edge of current bit).
- sampled_bit  in  1  majority-voted bit from data sampler; valid from check edge onward.
- par_err_in  in  1  parity checker result for the received byte + parity bit.
- Edge_EN_CNT  out  1  edge counter enable.
- Bit_EN_CNT  out  1  bit counter enable; 0 clears Bit_Counter.
- dat_samp_en  out  1  data sampler enable.
- deser_en  out  1  one-cycle shift strobe to deserializer.
- par_chk_en  out  1  one-cycle parity checker strobe.
- data_valid  out  1  one-cycle pulse: byte accepted without error.
- par_err  out  1  parity error of last completed frame.
- stp_err  out  1  stop error of last completed frame.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Check edge: CHK = (prescaler>>1)+1, computed in 6 bits and compared with zero-extended Edge_Counter. CHK is 5, 9 or 17 for prescaler 8, 16 or 32.
- IDLE: all enables 0. RX_IN==0 → START.
- START: Edge_EN_CNT=1, dat_samp_en=1. At CHK, latch glitch=sampled_bit. At Done: glitch=1 → IDLE with no data_valid and error flags unchanged; else → DATA.
- DATA: Edge_EN_CNT=1, Bit_EN_CNT=1, dat_samp_en=1, deser_en=1 at CHK. At Done with Bit_Counter==7: PAR_EN → PARITY, else → STOP.
- PARITY: Edge_EN_CNT=1, dat_samp_en=1, par_chk_en=1 at CHK. Latch par_err_in at CHK+1 into internal pe. At Done → STOP.
- STOP: Edge_EN_CNT=1, dat_samp_en=1. Latch se=~sampled_bit at CHK. At Done → IDLE.
- On that Done, register par_err←pe (forced 0 if !PAR_EN) and stp_err←se. data_valid=1 when both are 0.
- Bit_EN_CNT=0 outside DATA; this clears Bit_Counter before the next frame.
- pe and se clear on entry to START.

## Timing
- State register and data_valid/par_err/stp_err/glitch/pe/se are flops. Enables are combinational from state and Edge_Counter, so the counter sees them in the same cycle.
- Reset values: state IDLE; all outputs 0; glitch, pe and se 0.
- Start detection latency: RX_IN low sampled at edge t gives state START at t+1, with Edge_EN_CNT=1 in that cycle.
- Frame length from START entry to IDLE: (10 + PAR_EN) × prescaler cycles.
- data_valid, par_err and stp_err update in the cycle after the STOP Done edge. data_valid is high for exactly 1 cycle. Error flags hold until the next completed frame.
- The next frame can start one cycle after STOP exit, since IDLE re-examines RX_IN.
- RST asserted mid-frame: immediate return to IDLE with all outputs 0. The partial byte is dropped.
- RX_IN rising during START before CHK does not abort early; the abort happens only at Done.
- Edge_Counter is 0 on every IDLE exit, because Done wraps it and reset clears it.

## Structure
- Shared uart_rx_pkg holds the state encoding localparams (3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), DATA_BITS=8 and LAST_BIT=3'd7.
- No sub-module. One file with a state register, next-state logic, output decode and error latches.

## Test plan
- prescaler=8, PAR_EN=0, byte 0xA5 with valid stop → deser_en pulses 8 times at Edge_Counter=5. data_valid=1 for 1 cycle, 80 cycles after START entry. par_err=0, stp_err=0.
- prescaler=16, PAR_EN=1, byte 0x3C with correct parity (par_err_in=0) → data_valid after 176 cycles; par_chk_en pulses once at Edge_Counter=9.
- Start glitch: RX_IN low for 3 cycles at prescaler=16 → sampled_bit=1 at CHK, IDLE after Done. No deser_en, no data_valid, flags unchanged.
- Stop bit 0 at prescaler=32 → stp_err=1, data_valid=0. A following good frame clears stp_err and gives data_valid=1.
- Parity error (par_err_in=1), then back-to-back frame starting 1 cycle after STOP exit → par_err=1 on frame 1. Frame 2 is received correctly and clears par_err.
- RST pulsed low during DATA at Bit_Counter=4 → asynchronous return to IDLE, all outputs 0. The next full frame is received correctly.
